// File: rtl/tl45_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and instruction memory (slave).
//
// Handshake: req is a valid-style request. While req=1, addr is held stable up to
// and including the cycle in which ack=1. ack is a one-cycle completion strobe that
// is meaningful only while req=1, and data is valid only in that ack cycle. The
// master never withdraws a request before its ack; only reset can drop it. ack may
// already arrive in the first cycle of a request.
interface tl45_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/tl45_fetch.sv
// tl45 instruction fetch stage: fetches one word per request from instruction memory
// and feeds (pc, inst) to decode. It holds its output during a downstream stall,
// parks a word that arrives during a stall, and redirects on flush. A request made
// stale by a flush is waited out in DISCARD, because the bus never withdraws requests.
module tl45_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INST = 32'hF000_0000
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_pipe_stall,
   input  logic          i_pipe_flush,
   input  logic [31:0]   i_flush_pc,
   tl45_fetch_if.master  mem,
   output logic [31:0]   o_buf_pc,
   output logic [31:0]   o_buf_inst,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_inst_q, hold_inst_d;

   // An ack only counts while a request is actually outstanding.
   logic ack;
   assign ack = mem.ack & req_q;

   // State register; reset overrides everything, including an outstanding request.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         req_q       <= 1'b0;
         buf_pc_q    <= 32'h0;
         buf_inst_q  <= BUBBLE_INST;
         hold_pc_q   <= 32'h0;
         hold_inst_q <= BUBBLE_INST;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         buf_pc_q    <= buf_pc_d;
         buf_inst_q  <= buf_inst_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
      end
   end

   // Next-state and next-output logic; flush takes priority over stall and ack.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      req_d       = req_q;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;

      if (i_pipe_flush) begin
         buf_pc_d   = 32'h0;
         buf_inst_d = BUBBLE_INST;
         pc_d       = i_flush_pc;
      end

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = i_pipe_flush ? i_flush_pc : pc_q;
         end

         FETCH: begin
            if (i_pipe_flush) begin
               if (ack) begin
                  // Returned word belongs to the old stream; restart at the target.
                  addr_d = i_flush_pc;
               end else begin
                  // Request must still complete; keep addr stable and wait it out.
                  state_d = DISCARD;
               end
            end else if (ack && !i_pipe_stall) begin
               buf_pc_d   = pc_q;
               buf_inst_d = mem.data;
               pc_d       = pc_q + 32'd1;
               addr_d     = pc_q + 32'd1;
            end else if (ack && i_pipe_stall) begin
               // Decode cannot take it now; park the word and stop requesting.
               hold_pc_d   = pc_q;
               hold_inst_d = mem.data;
               pc_d        = pc_q + 32'd1;
               req_d       = 1'b0;
               state_d     = HOLD;
            end else if (!i_pipe_stall) begin
               buf_pc_d   = 32'h0;
               buf_inst_d = BUBBLE_INST;
            end
         end

         HOLD: begin
            if (i_pipe_flush) begin
               req_d   = 1'b1;
               addr_d  = i_flush_pc;
               state_d = FETCH;
            end else if (!i_pipe_stall) begin
               buf_pc_d   = hold_pc_q;
               buf_inst_d = hold_inst_q;
               req_d      = 1'b1;
               addr_d     = pc_q;
               state_d    = FETCH;
            end
         end

         DISCARD: begin
            buf_pc_d   = 32'h0;
            buf_inst_d = BUBBLE_INST;
            if (ack) begin
               // Stale word dropped; the next request goes to the latest target.
               addr_d  = i_pipe_flush ? i_flush_pc : pc_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign mem.req    = req_q;
   assign mem.addr   = addr_q;
   assign o_buf_pc   = buf_pc_q;
   assign o_buf_inst = buf_inst_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// Directed testbench for tl45_fetch: reset, streaming, wait states, stall/hold,
// flush during an outstanding request, flush+stall+ack, reset in DISCARD, pc wrap.
module tb_tl45_fetch;

   localparam logic [31:0] BUBBLE = 32'hF000_0000;
   localparam logic [1:0]  S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_DISCARD = 2'd3;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_pipe_stall;
   logic        i_pipe_flush;
   logic [31:0] i_flush_pc;
   logic [31:0] o_buf_pc;
   logic [31:0] o_buf_inst;
   logic [1:0]  dbg_state;

   // Memory model: either acks every request cycle with 1000_0000|addr, or is
   // driven by hand from the directed steps.
   logic        auto_ack;
   logic        manual_ack;
   logic [31:0] manual_data;

   int checks = 0;
   int errors = 0;

   tl45_fetch_if mem ();

   assign mem.ack  = auto_ack ? mem.req : manual_ack;
   assign mem.data = auto_ack ? (32'h1000_0000 | mem.addr) : manual_data;

   tl45_fetch dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_pipe_stall (i_pipe_stall),
      .i_pipe_flush (i_pipe_flush),
      .i_flush_pc   (i_flush_pc),
      .mem          (mem),
      .o_buf_pc     (o_buf_pc),
      .o_buf_inst   (o_buf_inst),
      .dbg_state    (dbg_state)
   );

   // Clock
   always #5 i_clk = ~i_clk;

   // Advance one clock and settle past the edge before sampling or driving.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_buf(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      check({tag, "_pc"}, o_buf_pc, pc);
      check({tag, "_inst"}, o_buf_inst, inst);
   endtask

   task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
      check({tag, "_req"}, {31'h0, mem.req}, {31'h0, req});
      if (req) check({tag, "_addr"}, mem.addr, addr);
   endtask

   initial begin
      i_reset      = 1'b1;
      i_pipe_stall = 1'b0;
      i_pipe_flush = 1'b0;
      i_flush_pc   = 32'h0;
      auto_ack     = 1'b0;
      manual_ack   = 1'b0;
      manual_data  = 32'h0;

      // Reset state
      step();
      step();
      check_req("rst", 1'b0, 32'h0);
      check_buf("rst", 32'h0, BUBBLE);
      check("rst_state", {30'h0, dbg_state}, {30'h0, S_IDLE});

      // 1: zero-wait streaming
      auto_ack = 1'b1;
      i_reset  = 1'b0;
      step();
      check_req("t1_first", 1'b1, 32'h0);
      check_buf("t1_first", 32'h0, BUBBLE);
      for (int i = 0; i < 3; i++) begin
         step();
         check_buf($sformatf("t1_seq%0d", i), i, 32'h1000_0000 | i);
         check_req($sformatf("t1_seq%0d", i), 1'b1, i + 1);
      end

      // 2: ack for addr 0 delayed by 3 cycles
      auto_ack = 1'b0;
      i_reset  = 1'b1;
      step();
      check_req("t2_rst", 1'b0, 32'h0);
      i_reset = 1'b0;
      step();
      check_req("t2_req", 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_buf($sformatf("t2_wait%0d", i), 32'h0, BUBBLE);
         check_req($sformatf("t2_wait%0d", i), 1'b1, 32'h0);
      end
      manual_ack  = 1'b1;
      manual_data = 32'h1234_5678;
      step();
      manual_ack = 1'b0;
      check_buf("t2_ack", 32'h0, 32'h1234_5678);
      check_req("t2_ack", 1'b1, 32'h1);

      // 3: stall in the ack cycle of addr 5, held 4 cycles
      auto_ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check_req("t3_pre", 1'b1, 32'h5);
      check_buf("t3_pre", 32'h4, 32'h1000_0004);
      i_pipe_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_req($sformatf("t3_hold%0d", i), 1'b0, 32'h0);
         check_buf($sformatf("t3_hold%0d", i), 32'h4, 32'h1000_0004);
      end
      check("t3_state", {30'h0, dbg_state}, {30'h0, S_HOLD});
      i_pipe_stall = 1'b0;
      step();
      check_buf("t3_rel", 32'h5, 32'h1000_0005);
      check_req("t3_rel", 1'b1, 32'h6);
      step();
      check_buf("t3_next", 32'h6, 32'h1000_0006);
      check_req("t3_next", 1'b1, 32'h7);

      // 4: flush to 0x40 while addr 7 outstanding; stale DEADBEEF dropped
      auto_ack     = 1'b0;
      manual_ack   = 1'b0;
      i_pipe_flush = 1'b1;
      i_flush_pc   = 32'h40;
      step();
      i_pipe_flush = 1'b0;
      check("t4_state", {30'h0, dbg_state}, {30'h0, S_DISCARD});
      check_req("t4_disc", 1'b1, 32'h7);
      check_buf("t4_disc", 32'h0, BUBBLE);
      step();
      check_req("t4_wait", 1'b1, 32'h7);
      manual_ack  = 1'b1;
      manual_data = 32'hDEAD_BEEF;
      step();
      manual_ack = 1'b0;
      check_buf("t4_drop", 32'h0, BUBBLE);
      check_req("t4_redir", 1'b1, 32'h40);
      check("t4_fetch", {30'h0, dbg_state}, {30'h0, S_FETCH});

      // 5: flush + stall + ack in the same cycle
      manual_ack   = 1'b1;
      manual_data  = 32'h1111_1111;
      i_pipe_stall = 1'b1;
      i_pipe_flush = 1'b1;
      i_flush_pc   = 32'h80;
      step();
      manual_ack   = 1'b0;
      i_pipe_stall = 1'b0;
      i_pipe_flush = 1'b0;
      check_buf("t5_flush", 32'h0, BUBBLE);
      check_req("t5_flush", 1'b1, 32'h80);
      auto_ack = 1'b1;
      step();
      check_buf("t5_next", 32'h80, 32'h1000_0080);

      // 6: reset while in DISCARD, then pc wrap
      auto_ack     = 1'b0;
      i_pipe_flush = 1'b1;
      i_flush_pc   = 32'h100;
      step();
      i_pipe_flush = 1'b0;
      check("t6_disc", {30'h0, dbg_state}, {30'h0, S_DISCARD});
      i_reset = 1'b1;
      step();
      check_req("t6_rst", 1'b0, 32'h0);
      check("t6_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});
      i_reset = 1'b0;
      step();
      check_req("t6_restart", 1'b1, 32'h0);
      manual_ack   = 1'b1;
      manual_data  = 32'h2222_2222;
      i_pipe_flush = 1'b1;
      i_flush_pc   = 32'hFFFF_FFFF;
      step();
      manual_ack   = 1'b0;
      i_pipe_flush = 1'b0;
      check_req("t6_top", 1'b1, 32'hFFFF_FFFF);
      auto_ack = 1'b1;
      step();
      check_buf("t6_top", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_req("t6_wrap", 1'b1, 32'h0);
      step();
      check_buf("t6_wrap", 32'h0, 32'h1000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
